// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, ALU op codes, state encodings and control word
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ_EX   = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
  } ctrl_word_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - controller <-> datapath bundle
interface mips_multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       pc_source;
  logic [1:0]       alu_op;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_retired;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
           alu_op, illegal_op, instr_retired
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
           alu_op, illegal_op, instr_retired
  );
endinterface

// File: rtl/mips_ctrl_outdec.sv
// rtl/mips_ctrl_outdec.sv - state (+ memory ready) to datapath control word
module mips_ctrl_outdec
  import mips_pkg::*;
(
  input  state_t     state_i,
  input  logic       ready_i,
  output ctrl_word_t ctrl_o
);

  // Moore decode; only FETCH gates its PC/IR loads on memory ready
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = 2'b01;
        ctrl_o.alu_op    = ALU_OP_ADD;
        ctrl_o.ir_write  = ready_i;
        ctrl_o.pc_write  = ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = 2'b11;
        ctrl_o.alu_op    = ALU_OP_ADD;
      end
      S_MEMADR, S_ADDI_EX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = 2'b10;
        ctrl_o.alu_op    = ALU_OP_ADD;
      end
      S_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      S_RTYPE_EX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALU_OP_FUNCT;
      end
      S_RTYPE_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_BEQ_EX: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_op        = ALU_OP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = 2'b01;
      end
      S_ADDI_WB: begin
        ctrl_o.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = 2'b10;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS main control FSM with retire counter
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter bit USE_READY = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  mips_multicycle_ctrl_if.master bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready;
  logic             illegal;
  logic             retire;
  ctrl_word_t       ctrl;
  ctrl_word_t       ctrl_g;

  assign ready = USE_READY ? bus.mem_ready : 1'b1;

  mips_ctrl_outdec u_outdec (
    .state_i (state_q),
    .ready_i (ready),
    .ctrl_o  (ctrl)
  );

  // Next state, illegal-opcode detect and retire condition
  always_comb begin
    state_d = S_FETCH;
    illegal = 1'b0;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  state_d = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPE_EX;
          OP_BEQ:       state_d = S_BEQ_EX;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    state_d = ready ? S_MEMWB : S_MEMRD;
      S_MEMWR: begin
        state_d = ready ? S_FETCH : S_MEMWR;
        retire  = ready;
      end
      S_RTYPE_EX: state_d = S_RTYPE_WB;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      S_MEMWB, S_RTYPE_WB, S_BEQ_EX, S_ADDI_WB, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default:    state_d = S_FETCH;
    endcase
  end

  // Counter wraps naturally at CNT_W bits
  always_comb begin
    cnt_d = cnt_q;
    if (retire) cnt_d = cnt_q + CNT_W'(1);
  end

  // State and retire counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Force every control low while reset is held, even though state sits in FETCH
  always_comb begin
    ctrl_g = rst_n ? ctrl : '0;
  end

  assign bus.pc_write      = ctrl_g.pc_write;
  assign bus.pc_write_cond = ctrl_g.pc_write_cond;
  assign bus.iord          = ctrl_g.iord;
  assign bus.mem_read      = ctrl_g.mem_read;
  assign bus.mem_write     = ctrl_g.mem_write;
  assign bus.ir_write      = ctrl_g.ir_write;
  assign bus.mem_to_reg    = ctrl_g.mem_to_reg;
  assign bus.reg_dst       = ctrl_g.reg_dst;
  assign bus.reg_write     = ctrl_g.reg_write;
  assign bus.alu_src_a     = ctrl_g.alu_src_a;
  assign bus.alu_src_b     = ctrl_g.alu_src_b;
  assign bus.pc_source     = ctrl_g.pc_source;
  assign bus.alu_op        = ctrl_g.alu_op;
  assign bus.illegal_op    = illegal & rst_n;
  assign bus.instr_retired = cnt_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - directed self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

  // Control word packing: {pc_write, pc_write_cond, iord, mem_read, mem_write,
  // ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0],
  // pc_source[1:0], alu_op[1:0]}
  localparam logic [15:0] W_ZERO    = 16'h0000;
  localparam logic [15:0] W_FETCH   = 16'h9410;
  localparam logic [15:0] W_FETCH_W = 16'h1010;
  localparam logic [15:0] W_DECODE  = 16'h0030;
  localparam logic [15:0] W_MEMADR  = 16'h0060;
  localparam logic [15:0] W_MEMRD   = 16'h3000;
  localparam logic [15:0] W_MEMWB   = 16'h0280;
  localparam logic [15:0] W_MEMWR   = 16'h2800;
  localparam logic [15:0] W_REX     = 16'h0042;
  localparam logic [15:0] W_RWB     = 16'h0180;
  localparam logic [15:0] W_BEQ     = 16'h4045;
  localparam logic [15:0] W_ADDI_EX = 16'h0060;
  localparam logic [15:0] W_JUMP    = 16'h8008;

  logic clk = 1'b0;
  logic rst_n;
  int   vecs = 0;
  int   miss = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl_if #(.CNT_W(32)) b0 ();
  mips_multicycle_ctrl_if #(.CNT_W(4))  b1 ();
  mips_multicycle_ctrl_if #(.CNT_W(32)) b2 ();

  mips_multicycle_ctrl #(.CNT_W(32), .USE_READY(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  mips_multicycle_ctrl #(.CNT_W(4),  .USE_READY(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  mips_multicycle_ctrl #(.CNT_W(32), .USE_READY(1'b0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  function automatic logic [15:0] w0();
    return {b0.pc_write, b0.pc_write_cond, b0.iord, b0.mem_read, b0.mem_write,
            b0.ir_write, b0.mem_to_reg, b0.reg_dst, b0.reg_write, b0.alu_src_a,
            b0.alu_src_b, b0.pc_source, b0.alu_op};
  endfunction

  function automatic logic [15:0] w2();
    return {b2.pc_write, b2.pc_write_cond, b2.iord, b2.mem_read, b2.mem_write,
            b2.ir_write, b2.mem_to_reg, b2.reg_dst, b2.reg_write, b2.alu_src_a,
            b2.alu_src_b, b2.pc_source, b2.alu_op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_all();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    b0.opcode    = 6'b000000;
    b0.mem_ready = 1'b1;
    b1.opcode    = 6'b001000;
    b1.mem_ready = 1'b1;
    b2.opcode    = 6'b100011;
    b2.mem_ready = 1'b0;

    // Reset held: everything low, counter zero
    repeat (2) @(negedge clk);
    #1;
    chk("rst_word", {16'h0, w0()}, {16'h0, W_ZERO});
    chk("rst_cnt", b0.instr_retired, 32'd0);

    // Release, reach DECODE, then assert reset asynchronously mid-DECODE
    rst_n = 1'b1;
    tick();
    chk("pre_rst_decode", {16'h0, w0()}, {16'h0, W_DECODE});
    rst_n = 1'b0;
    #1;
    chk("async_rst_word", {16'h0, w0()}, {16'h0, W_ZERO});
    chk("async_rst_ill", {31'h0, b0.illegal_op}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_fetch", {16'h0, w0()}, {16'h0, W_FETCH});
    chk("post_rst_cnt", b0.instr_retired, 32'd0);

    // R-type, zero wait
    tick();
    chk("r_decode", {16'h0, w0()}, {16'h0, W_DECODE});
    chk("r_decode_ill", {31'h0, b0.illegal_op}, 32'd0);
    tick();
    chk("r_ex", {16'h0, w0()}, {16'h0, W_REX});
    tick();
    chk("r_wb", {16'h0, w0()}, {16'h0, W_RWB});
    tick();
    chk("r_done_fetch", {16'h0, w0()}, {16'h0, W_FETCH});
    chk("r_cnt", b0.instr_retired, 32'd1);

    // lw with two wait cycles in MEMRD
    b0.opcode = 6'b100011;
    tick();
    chk("lw_decode", {16'h0, w0()}, {16'h0, W_DECODE});
    tick();
    chk("lw_memadr", {16'h0, w0()}, {16'h0, W_MEMADR});
    b0.mem_ready = 1'b0;
    tick();
    chk("lw_memrd_w1", {16'h0, w0()}, {16'h0, W_MEMRD});
    tick();
    chk("lw_memrd_w2", {16'h0, w0()}, {16'h0, W_MEMRD});
    tick();
    b0.mem_ready = 1'b1;
    #1;
    chk("lw_memrd_rdy", {16'h0, w0()}, {16'h0, W_MEMRD});
    tick();
    chk("lw_memwb", {16'h0, w0()}, {16'h0, W_MEMWB});
    tick();
    chk("lw_done_fetch", {16'h0, w0()}, {16'h0, W_FETCH});
    chk("lw_cnt", b0.instr_retired, 32'd2);

    // FETCH waiting on memory: no PC/IR load, stays in FETCH
    b0.mem_ready = 1'b0;
    #1;
    chk("fetch_wait", {16'h0, w0()}, {16'h0, W_FETCH_W});
    tick();
    chk("fetch_wait_hold", {16'h0, w0()}, {16'h0, W_FETCH_W});
    b0.mem_ready = 1'b1;

    // sw, beq, j from fresh reset: counts 1,2,3
    reset_all();
    b0.opcode = 6'b101011;
    tick();
    tick();
    chk("sw_memadr", {16'h0, w0()}, {16'h0, W_MEMADR});
    tick();
    chk("sw_memwr", {16'h0, w0()}, {16'h0, W_MEMWR});
    tick();
    chk("sw_cnt", b0.instr_retired, 32'd1);
    b0.opcode = 6'b000100;
    tick();
    tick();
    chk("beq_ex", {16'h0, w0()}, {16'h0, W_BEQ});
    tick();
    chk("beq_cnt", b0.instr_retired, 32'd2);
    b0.opcode = 6'b000010;
    tick();
    tick();
    chk("j_jump", {16'h0, w0()}, {16'h0, W_JUMP});
    tick();
    chk("j_cnt", b0.instr_retired, 32'd3);
    chk("j_back_fetch", {16'h0, w0()}, {16'h0, W_FETCH});

    // Illegal opcode
    b0.opcode = 6'b111111;
    tick();
    chk("ill_pulse", {31'h0, b0.illegal_op}, 32'd1);
    chk("ill_decode", {16'h0, w0()}, {16'h0, W_DECODE});
    tick();
    chk("ill_clear", {31'h0, b0.illegal_op}, 32'd0);
    chk("ill_fetch", {16'h0, w0()}, {16'h0, W_FETCH});
    chk("ill_cnt", b0.instr_retired, 32'd3);

    // CNT_W=4 addi wrap, concurrent with USE_READY=0 lw
    reset_all();
    chk("nr_fetch", {16'h0, w2()}, {16'h0, W_FETCH});
    tick();
    tick();
    chk("addi_ex", {16'h0, b1.pc_write, b1.pc_write_cond, b1.iord, b1.mem_read,
        b1.mem_write, b1.ir_write, b1.mem_to_reg, b1.reg_dst, b1.reg_write,
        b1.alu_src_a, b1.alu_src_b, b1.pc_source, b1.alu_op}, {16'h0, W_ADDI_EX});
    tick();
    chk("nr_memrd", {16'h0, w2()}, {16'h0, W_MEMRD});
    tick();
    chk("nr_memwb", {16'h0, w2()}, {16'h0, W_MEMWB});
    chk("addi_cnt1", {28'h0, b1.instr_retired}, 32'd1);
    tick();
    chk("nr_cnt", b2.instr_retired, 32'd1);
    for (int i = 5; i < 60; i++) tick();
    chk("addi_cnt15", {28'h0, b1.instr_retired}, 32'd15);
    repeat (4) tick();
    chk("addi_wrap0", {28'h0, b1.instr_retired}, 32'd0);
    repeat (4) tick();
    chk("addi_wrap1", {28'h0, b1.instr_retired}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
